// File: rtl/fsm_driver.sv
// fsm_driver: sequences the drive line A through a fixed rise/fall/handshake
// pattern and reports completion or failure to the requester.
//
// Ports
//   Clock      in   single clock, all state changes on its rising edge
//   Reset      in   synchronous active-low reset
//   Start_req  in   request to run one A-sequence
//   Start_rdy  out  high when a request can be accepted (state IDLE)
//   Dwell      in   [DW-1:0] phase dwell length, sampled at accept (0 acts as 1)
//   K2         in   acknowledge: Stop-to-Clear seen (used in RISE2)
//   K1         in   acknowledge: Clear-to-Idle seen (used in FALL2)
//   A          out  registered drive to the controlled block
//   Busy       out  high while a sequence is in progress
//   Done       out  one-cycle pulse on successful completion
//   Err        out  one-cycle pulse on failed completion
//   Err_code   out  [1:0] 00 none, 01 K2 timeout, 10 K1 timeout, 11 K1&K2 together
//
// state | meaning
// IDLE  | waiting for Start_req, A low
// RISE1 | A high for D cycles
// FALL1 | A low for D cycles
// RISE2 | A high, waiting up to TO cycles for K2
// HOLD  | A high for D cycles
// FALL2 | A low, waiting up to TO cycles for K1

module fsm_driver #(
    parameter int DW = 8,
    parameter int TO = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Start_req,
    output logic          Start_rdy,
    input  logic [DW-1:0] Dwell,
    input  logic          K2,
    input  logic          K1,
    output logic          A,
    output logic          Busy,
    output logic          Done,
    output logic          Err,
    output logic [1:0]    Err_code
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RISE1 = 3'd1,
        FALL1 = 3'd2,
        RISE2 = 3'd3,
        HOLD  = 3'd4,
        FALL2 = 3'd5
    } state_t;

    // Wait counter starts at TO-1 and expires on reaching zero, so the
    // last cycle in which an acknowledge is still honoured is cycle TO.
    localparam logic [7:0]    WAIT_LOAD = 8'(TO - 1);
    localparam logic [DW-1:0] DW_ONE    = DW'(1);

    state_t        state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;   // effective dwell minus one
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [7:0]    wcnt_q, wcnt_d;
    logic          a_q, a_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic [DW-1:0] dwell_m1;

    // Dwell of zero is treated as one, so the terminal count is max(Dwell,1)-1.
    assign dwell_m1 = (Dwell == '0) ? '0 : (Dwell - DW_ONE);

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        dcnt_d  = dcnt_q;
        wcnt_d  = wcnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;

        case (state_q)
            IDLE: begin
                if (Start_req) begin
                    state_d = RISE1;
                    dwell_d = dwell_m1;
                    dcnt_d  = dwell_m1;
                    code_d  = 2'b00;
                end
            end
            RISE1: begin
                if (dcnt_q == '0) begin
                    state_d = FALL1;
                    dcnt_d  = dwell_q;
                end else begin
                    dcnt_d = dcnt_q - DW_ONE;
                end
            end
            FALL1: begin
                if (dcnt_q == '0) begin
                    state_d = RISE2;
                    wcnt_d  = WAIT_LOAD;
                end else begin
                    dcnt_d = dcnt_q - DW_ONE;
                end
            end
            RISE2: begin
                if (K1 && K2) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    code_d  = 2'b11;
                end else if (K2) begin
                    state_d = HOLD;
                    dcnt_d  = dwell_q;
                end else if (wcnt_q == 8'd0) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    code_d  = 2'b01;
                end else begin
                    wcnt_d = wcnt_q - 8'd1;
                end
            end
            HOLD: begin
                if (dcnt_q == '0) begin
                    state_d = FALL2;
                    wcnt_d  = WAIT_LOAD;
                end else begin
                    dcnt_d = dcnt_q - DW_ONE;
                end
            end
            FALL2: begin
                if (K1 && K2) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    code_d  = 2'b11;
                end else if (K1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (wcnt_q == 8'd0) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    code_d  = 2'b10;
                end else begin
                    wcnt_d = wcnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A follows the state being entered, so it only moves on transitions.
        a_d = (state_d == RISE1) || (state_d == RISE2) || (state_d == HOLD);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= IDLE;
            dwell_q <= '0;
            dcnt_q  <= '0;
            wcnt_q  <= 8'd0;
            a_q     <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            dcnt_q  <= dcnt_d;
            wcnt_q  <= wcnt_d;
            a_q     <= a_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign Start_rdy = (state_q == IDLE);
    assign Busy      = (state_q != IDLE);
    assign A         = a_q;
    assign Done      = done_q;
    assign Err       = err_q;
    assign Err_code  = code_q;

endmodule

// File: tb/tb_fsm_driver.sv
// Self-checking bench for fsm_driver. The reference model describes each
// sequence by its phase lengths (D, k2, k1, TO) and derives the expected
// A waveform, completion cycle and result code arithmetically.

module tb_fsm_driver;

    localparam int DW = 8;
    localparam int TO = 16;

    localparam int K_OK    = 0;  // K2 at k2, K1 at k1
    localparam int K_K2TO  = 1;  // K2 never arrives
    localparam int K_K1TO  = 2;  // K2 at k2, K1 never arrives
    localparam int K_BOTH2 = 3;  // K1 and K2 together at RISE2 cycle k2
    localparam int K_BOTH1 = 4;  // K2 at k2, then K1 and K2 together at FALL2 cycle k1

    logic          clk;
    logic          rst_b;
    logic          start_req;
    logic          start_rdy;
    logic [DW-1:0] dwell;
    logic          k2;
    logic          k1;
    logic          a;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;

    int n_cmp = 0;
    int n_bad = 0;
    int last_code = 0;

    fsm_driver #(.DW(DW), .TO(TO)) dut (
        .Clock     (clk),
        .Reset     (rst_b),
        .Start_req (start_req),
        .Start_rdy (start_rdy),
        .Dwell     (dwell),
        .K2        (k2),
        .K1        (k1),
        .A         (a),
        .Busy      (busy),
        .Done      (done),
        .Err       (err),
        .Err_code  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected A in cycle i (1 = first cycle after accept).
    function automatic int exp_a(input int i, input int d, input int w2);
        if (i <= d)              return 1;
        if (i <= 2*d)            return 0;
        if (i <= 3*d + w2)       return 1;
        return 0;
    endfunction

    // Entered at #1 after an edge with the DUT idle (or in its Done/Err cycle).
    task automatic run_seq(input int dw, input int kind, input int kk2, input int kk1,
                           input int rst_at, input bit busy_noise);
        int d, n, code, w2, j;
        d  = (dw == 0) ? 1 : dw;
        w2 = (kind == K_K2TO) ? TO : kk2;
        case (kind)
            K_OK:    begin n = 3*d + kk2 + kk1; code = 0; end
            K_K2TO:  begin n = 2*d + TO;        code = 1; end
            K_K1TO:  begin n = 3*d + kk2 + TO;  code = 2; end
            K_BOTH2: begin n = 2*d + kk2;       code = 3; end
            default: begin n = 3*d + kk2 + kk1; code = 3; end
        endcase

        start_req = 1'b1;
        dwell     = dw[DW-1:0];
        k1        = 1'($urandom_range(0, 1));
        k2        = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("accept_rdy", start_rdy, 1);
        @(posedge clk); #1;

        for (int i = 1; i <= n; i++) begin
            start_req = busy_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            dwell     = DW'($urandom);
            if (i <= 2*d || (i > 2*d + w2 && i <= 3*d + w2)) begin
                // dwell phases ignore both acknowledges
                k1 = 1'($urandom_range(0, 1));
                k2 = 1'($urandom_range(0, 1));
            end else if (i <= 2*d + w2) begin
                j  = i - 2*d;
                k2 = (kind != K_K2TO) && (j == kk2);
                k1 = (kind == K_BOTH2) && (j == kk2);
            end else begin
                j  = i - 3*d - w2;
                k1 = (kind == K_OK || kind == K_BOTH1) && (j == kk1);
                k2 = (kind == K_BOTH1) && (j == kk1);
            end
            if (rst_at == i) rst_b = 1'b0;

            @(negedge clk);
            chk("busy_seq", busy, 1);
            chk("a_seq", a, exp_a(i, d, w2));
            chk("done_seq", done, 0);
            chk("err_seq", err, 0);
            chk("code_seq", err_code, 0);
            @(posedge clk); #1;

            if (rst_at == i) begin
                rst_b     = 1'b1;
                start_req = 1'b0;
                k1        = 1'b0;
                k2        = 1'b0;
                chk("rst_a", a, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_err", err, 0);
                chk("rst_code", err_code, 0);
                last_code = 0;
                return;
            end
        end

        start_req = 1'b0;
        k1        = 1'b0;
        k2        = 1'b0;
        chk("end_busy", busy, 0);
        chk("end_rdy", start_rdy, 1);
        chk("end_a", a, 0);
        chk("end_done", done, (code == 0) ? 1 : 0);
        chk("end_err", err, (code != 0) ? 1 : 0);
        chk("end_code", err_code, code);
        last_code = code;
    endtask

    task automatic idle_gap(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            start_req = 1'b0;
            k1        = 1'($urandom_range(0, 1));
            k2        = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("idle_busy", busy, 0);
            chk("idle_a", a, 0);
            chk("idle_done", done, 0);
            chk("idle_err", err, 0);
            chk("idle_code", err_code, last_code);
            chk("idle_rdy", start_rdy, 1);
        end
        k1 = 1'b0;
        k2 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        rst_b     = 1'b0;
        start_req = 1'b1;   // held through reset, accepted on the first edge after release
        dwell     = 8'd2;
        k1        = 1'b1;
        k2        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", a, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_code", err_code, 0);
        rst_b = 1'b1;

        // Dwell=3, K2 two cycles into RISE2, K1 first cycle of FALL2: 12 cycles
        run_seq(3, K_OK, 2, 1, 0, 1'b0);
        idle_gap(2);
        // Dwell=0 and Dwell=1 behave identically
        run_seq(0, K_OK, 1, 1, 0, 1'b0);
        run_seq(1, K_OK, 1, 1, 0, 1'b0);
        // K2 never arrives: RISE2 lasts TO cycles, code 01 held afterwards
        run_seq(2, K_K2TO, 1, 1, 0, 1'b0);
        idle_gap(3);
        // K1 never arrives
        run_seq(2, K_K1TO, 4, 1, 0, 1'b0);
        idle_gap(1);
        // K1 and K2 together in FALL2 and in RISE2
        run_seq(2, K_BOTH1, 3, 2, 0, 1'b0);
        run_seq(1, K_BOTH2, 5, 1, 0, 1'b0);
        // acknowledges in the very last legal wait cycle
        run_seq(1, K_OK, TO, TO, 0, 1'b0);
        // reset during HOLD, then a normal sequence
        run_seq(3, K_OK, 2, 1, 2*3 + 2 + 2, 1'b0);
        run_seq(3, K_OK, 2, 1, 0, 1'b0);
        // back-to-back with request pulses while busy
        run_seq(2, K_OK, 3, 2, 0, 1'b1);
        run_seq(4, K_OK, 1, 5, 0, 1'b1);
        // largest dwell
        run_seq(255, K_OK, 1, 1, 0, 1'b0);
        idle_gap(1);

        for (int s = 0; s < 40; s++) begin
            run_seq($urandom_range(0, 6), $urandom_range(0, 4),
                    $urandom_range(1, TO), $urandom_range(1, TO),
                    0, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_gap($urandom_range(1, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
